icache_mem_arbiter: RTL and testbench

- Shares one program-memory read port among NUM_CONSUMERS per-core instruction caches.
- Grants are round-robin, one transaction outstanding at a time.
- Requester side uses the icache two-pulse handshake: an accept pulse on ready, then a response pulse on ready carrying data.
- Sits between the per-core icaches and the program memory controller; exports contention statistics.

---
 rtl/icache_mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_icache_mem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_mem_arbiter.sv
// icache_mem_arbiter
//   Shares one program-memory read port among NUM_CONSUMERS instruction
//   caches. Requesters are granted round-robin with one memory transaction
//   in flight at a time. Each requester sees a two-pulse handshake on its
//   ready line: an accept pulse when it is granted, then a response pulse
//   that carries the fetched instruction on its data slice.
//
// Ports
//   clk, reset             clock; synchronous active-high reset
//   consumer_read_valid    per-requester request, held until accepted
//   consumer_read_address  flattened request addresses (ADDR_BITS each)
//   consumer_read_ready    per-requester accept / response pulses
//   consumer_read_data     flattened response data (DATA_BITS each)
//   mem_read_valid/address request to the program memory controller
//   mem_read_ready/data    memory response, data valid with ready
//   current_owner          last granted requester
//   busy                   a transaction is in flight
//   grant_count            total grants issued (wraps)
//   conflict_cycles        cycles in which a valid requester went ungranted
module icache_mem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  localparam int OW           = $clog2(NUM_CONSUMERS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  output logic                           mem_read_valid,
  output logic [ADDR_BITS-1:0]           mem_read_address,
  input  logic                           mem_read_ready,
  input  logic [DATA_BITS-1:0]           mem_read_data,
  output logic [OW-1:0]                  current_owner,
  output logic                           busy,
  output logic [31:0]                    grant_count,
  output logic [31:0]                    conflict_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  // First requester at or after ptr, scanning upward with wrap. The index
  // arithmetic wraps naturally because NUM_CONSUMERS is a power of two.
  function automatic logic [OW-1:0] rr_pick(input logic [NUM_CONSUMERS-1:0] req,
                                            input logic [OW-1:0] ptr);
    logic [OW-1:0] idx;
    logic          found;
    rr_pick = {OW{1'b0}};
    found   = 1'b0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      idx     = ptr + OW'(k);
      rr_pick = (!found && req[idx]) ? idx : rr_pick;
      found   = found | req[idx];
    end
  endfunction

  state_t                           r_state;
  logic [OW-1:0]                    r_ptr;
  logic [OW-1:0]                    r_owner;
  logic                             r_mem_valid;
  logic [ADDR_BITS-1:0]             r_mem_addr;
  logic [NUM_CONSUMERS-1:0]         r_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] r_data;
  logic [31:0]                      r_grant_count;
  logic [31:0]                      r_conflict;
  logic                             r_busy;

  state_t                           w_state_next;
  logic [OW-1:0]                    w_ptr_next;
  logic [OW-1:0]                    w_owner_next;
  logic                             w_mem_valid_next;
  logic [ADDR_BITS-1:0]             w_mem_addr_next;
  logic [NUM_CONSUMERS-1:0]         w_ready_next;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] w_data_next;
  logic [31:0]                      w_grant_count_next;
  logic [31:0]                      w_conflict_next;
  logic [NUM_CONSUMERS-1:0]         w_grant;
  logic [OW-1:0]                    w_winner;
  logic                             w_any;

  assign w_winner = rr_pick(consumer_read_valid, r_ptr);
  assign w_any    = |consumer_read_valid;

  // Next-state and next-output decode for the arbitration FSM and counters.
  always_comb begin
    w_state_next       = r_state;
    w_ptr_next         = r_ptr;
    w_owner_next       = r_owner;
    w_mem_valid_next   = r_mem_valid;
    w_mem_addr_next    = r_mem_addr;
    w_ready_next       = {NUM_CONSUMERS{1'b0}};
    w_data_next        = r_data;
    w_grant_count_next = r_grant_count;
    w_grant            = {NUM_CONSUMERS{1'b0}};

    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant[w_winner]      = 1'b1;
          w_owner_next           = w_winner;
          w_mem_addr_next        = consumer_read_address[w_winner*ADDR_BITS +: ADDR_BITS];
          w_mem_valid_next       = 1'b1;
          w_ready_next[w_winner] = 1'b1;
          w_grant_count_next     = r_grant_count + 32'd1;
          w_state_next           = ST_READ;
        end else begin
          w_mem_valid_next = 1'b0;
        end
      end
      ST_READ: begin
        // Ready drops after the accept pulse; it rises again only with data.
        if (mem_read_ready) begin
          w_mem_valid_next = 1'b0;
          w_data_next[r_owner*DATA_BITS +: DATA_BITS] = mem_read_data;
          w_ready_next[r_owner] = 1'b1;
          w_state_next     = ST_RESPOND;
        end else begin
          w_mem_valid_next = 1'b1;
        end
      end
      ST_RESPOND: begin
        w_ptr_next       = r_owner + OW'(1'b1);
        w_mem_valid_next = 1'b0;
        w_state_next     = ST_IDLE;
      end
      default: begin
        w_mem_valid_next = 1'b0;
        w_state_next     = ST_IDLE;
      end
    endcase

    // Any valid requester not being granted this very cycle is contention.
    if ((consumer_read_valid & ~w_grant) != {NUM_CONSUMERS{1'b0}}) begin
      w_conflict_next = r_conflict + 32'd1;
    end else begin
      w_conflict_next = r_conflict;
    end
  end

  // State, pointer, handshake outputs and statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_ptr         <= {OW{1'b0}};
      r_owner       <= {OW{1'b0}};
      r_mem_valid   <= 1'b0;
      r_mem_addr    <= {ADDR_BITS{1'b0}};
      r_ready       <= {NUM_CONSUMERS{1'b0}};
      r_data        <= {(NUM_CONSUMERS*DATA_BITS){1'b0}};
      r_grant_count <= 32'd0;
      r_conflict    <= 32'd0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_ptr         <= w_ptr_next;
      r_owner       <= w_owner_next;
      r_mem_valid   <= w_mem_valid_next;
      r_mem_addr    <= w_mem_addr_next;
      r_ready       <= w_ready_next;
      r_data        <= w_data_next;
      r_grant_count <= w_grant_count_next;
      r_conflict    <= w_conflict_next;
      r_busy        <= (w_state_next != ST_IDLE);
    end
  end

  assign consumer_read_ready = r_ready;
  assign consumer_read_data  = r_data;
  assign mem_read_valid      = r_mem_valid;
  assign mem_read_address    = r_mem_addr;
  assign current_owner       = r_owner;
  assign busy                = r_busy;
  assign grant_count         = r_grant_count;
  assign conflict_cycles     = r_conflict;

endmodule

// File: tb/tb_icache_mem_arbiter.sv
// Testbench for icache_mem_arbiter (NUM_CONSUMERS=4, ADDR_BITS=8, DATA_BITS=16).
module tb_icache_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  tb_valid;
  logic [31:0] tb_addr;
  logic [3:0]  tb_ready;
  logic [63:0] tb_data;
  logic        tb_mvalid;
  logic [7:0]  tb_maddr;
  logic        tb_mready;
  logic [15:0] tb_mdata;
  logic [1:0]  tb_owner;
  logic        tb_busy;
  logic [31:0] tb_gc;
  logic [31:0] tb_cf;

  int n_chk;
  int n_fail;

  icache_mem_arbiter #(.NUM_CONSUMERS(4), .ADDR_BITS(8), .DATA_BITS(16)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .consumer_read_valid   (tb_valid),
    .consumer_read_address (tb_addr),
    .consumer_read_ready   (tb_ready),
    .consumer_read_data    (tb_data),
    .mem_read_valid        (tb_mvalid),
    .mem_read_address      (tb_maddr),
    .mem_read_ready        (tb_mready),
    .mem_read_data         (tb_mdata),
    .current_owner         (tb_owner),
    .busy                  (tb_busy),
    .grant_count           (tb_gc),
    .conflict_cycles       (tb_cf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not seen within cycle budget", name);
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 3; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] addr;
    logic        mrdy;
    logic [15:0] mdata;
    logic [3:0]  e_ready;
    logic        e_mvalid;
    logic [7:0]  e_maddr;
    logic        e_busy;
    logic [1:0]  e_owner;
    logic [31:0] e_gc;
    logic [31:0] e_cf;
    logic [63:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [3:0] valid, input logic [31:0] addr,
                              input logic mrdy, input logic [15:0] mdata, input logic [3:0] e_ready,
                              input logic e_mvalid, input logic [7:0] e_maddr, input logic e_busy,
                              input logic [1:0] e_owner, input logic [31:0] e_gc,
                              input logic [31:0] e_cf, input logic [63:0] e_data);
    vec_t v;
    v.rst = rst; v.valid = valid; v.addr = addr; v.mrdy = mrdy; v.mdata = mdata;
    v.e_ready = e_ready; v.e_mvalid = e_mvalid; v.e_maddr = e_maddr; v.e_busy = e_busy;
    v.e_owner = e_owner; v.e_gc = e_gc; v.e_cf = e_cf; v.e_data = e_data;
    return v;
  endfunction

  vec_t vecs[12];

  // ---------------- handshake helpers ----------------
  task automatic wait_accept(input int exp_who, input bit drop);
    bit seen;
    int who;
    seen = 1'b0;
    for (int t = 0; t < 32 && !seen; t++) begin
      @(negedge clk);
      if (tb_ready != 4'b0000 && tb_mvalid) begin
        seen = 1'b1;
        who  = oh_idx(tb_ready);
        chk("grant_order", 64'(who), 64'(exp_who));
        chk("owner_at_accept", 64'(tb_owner), 64'(exp_who));
        if (drop) tb_valid[who] = 1'b0;
      end
    end
    if (!seen) fail_timeout("accept_wait");
  endtask

  task automatic wait_response(input int exp_who, input logic [15:0] exp_data);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 32 && !seen; t++) begin
      @(negedge clk);
      if (tb_ready != 4'b0000 && !tb_mvalid) begin
        seen = 1'b1;
        chk("resp_who", 64'(oh_idx(tb_ready)), 64'(exp_who));
        chk("resp_data", 64'(tb_data[exp_who*16 +: 16]), 64'(exp_data));
      end
    end
    if (!seen) begin
      fail_timeout("response_wait");
    end else begin
      @(negedge clk);
      chk("resp_pulse_len", 64'(tb_ready), 64'h0);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    tb_valid  = 4'b0000;
    tb_mready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- reference model for random traffic ----------------
  // Transaction timeline: a grant decided at edge c+1 makes cycle c+1 the
  // accept cycle; the first sampled mem ready in cycle r>=accept makes r+1
  // the response cycle; the arbiter is free again from response+1.
  bit          m_act;
  int          m_acc, m_rsp, m_own, m_ptr;
  logic [31:0] m_gc, m_cf;
  logic [7:0]  m_addr;
  logic [15:0] m_data [4];
  logic [3:0]  pend;
  logic [7:0]  raddr [4];

  function automatic bit m_busy(input int c);
    return m_act && c >= m_acc && (m_rsp < 0 || c <= m_rsp);
  endfunction

  function automatic bit m_read(input int c);
    return m_act && c >= m_acc && m_rsp < 0;
  endfunction

  function automatic int rr_first(input logic [3:0] req, input int ptr);
    int r;
    r = -1;
    for (int k = 3; k >= 0; k--) if (req[(ptr + k) % 4]) r = (ptr + k) % 4;
    return r;
  endfunction

  task automatic check_model(input int c);
    logic [3:0]  e_ready;
    logic [63:0] e_data;
    e_ready = 4'b0000;
    if (m_act && (c == m_acc || c == m_rsp)) e_ready[m_own] = 1'b1;
    for (int i = 0; i < 4; i++) e_data[i*16 +: 16] = m_data[i];
    chk("rnd_ready", 64'(tb_ready), 64'(e_ready));
    chk("rnd_mvalid", 64'(tb_mvalid), 64'(m_read(c)));
    chk("rnd_busy", 64'(tb_busy), 64'(m_busy(c)));
    chk("rnd_maddr", 64'(tb_maddr), 64'(m_addr));
    chk("rnd_owner", 64'(tb_owner), 64'(m_own));
    chk("rnd_gc", 64'(tb_gc), 64'(m_gc));
    chk("rnd_cf", 64'(tb_cf), 64'(m_cf));
    chk("rnd_data", tb_data, e_data);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0] g;
    int         w;
    n_chk  = 0;
    n_fail = 0;
    tb_mdata = 16'h0000;
    tb_addr  = 32'h0;

    // Single request to 1, then simultaneous 0 and 2, each after reset.
    vecs[0]  = mk(1'b1, 4'b0000, 32'h0000_0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 32'd0, 32'd0, 64'h0);
    vecs[1]  = mk(1'b0, 4'b0010, 32'h0000_2A00, 1'b0, 16'h0000, 4'b0010, 1'b1, 8'h2A, 1'b1, 2'd1, 32'd1, 32'd0, 64'h0);
    vecs[2]  = mk(1'b0, 4'b0000, 32'h0000_2A00, 1'b1, 16'hBEEF, 4'b0010, 1'b0, 8'h2A, 1'b1, 2'd1, 32'd1, 32'd0, 64'h0000_0000_BEEF_0000);
    vecs[3]  = mk(1'b0, 4'b0000, 32'h0000_0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 8'h2A, 1'b0, 2'd1, 32'd1, 32'd0, 64'h0000_0000_BEEF_0000);
    vecs[4]  = mk(1'b0, 4'b0000, 32'h0000_0000, 1'b1, 16'h1234, 4'b0000, 1'b0, 8'h2A, 1'b0, 2'd1, 32'd1, 32'd0, 64'h0000_0000_BEEF_0000);
    vecs[5]  = mk(1'b1, 4'b0000, 32'h0000_0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 32'd0, 32'd0, 64'h0);
    vecs[6]  = mk(1'b0, 4'b0101, 32'h0020_0010, 1'b0, 16'h0000, 4'b0001, 1'b1, 8'h10, 1'b1, 2'd0, 32'd1, 32'd1, 64'h0);
    vecs[7]  = mk(1'b0, 4'b0100, 32'h0020_0010, 1'b1, 16'h1111, 4'b0001, 1'b0, 8'h10, 1'b1, 2'd0, 32'd1, 32'd2, 64'h0000_0000_0000_1111);
    vecs[8]  = mk(1'b0, 4'b0100, 32'h0020_0010, 1'b0, 16'h0000, 4'b0000, 1'b0, 8'h10, 1'b0, 2'd0, 32'd1, 32'd3, 64'h0000_0000_0000_1111);
    vecs[9]  = mk(1'b0, 4'b0100, 32'h0020_0010, 1'b0, 16'h0000, 4'b0100, 1'b1, 8'h20, 1'b1, 2'd2, 32'd2, 32'd3, 64'h0000_0000_0000_1111);
    vecs[10] = mk(1'b0, 4'b0000, 32'h0020_0010, 1'b1, 16'h2222, 4'b0100, 1'b0, 8'h20, 1'b1, 2'd2, 32'd2, 32'd3, 64'h0000_2222_0000_1111);
    vecs[11] = mk(1'b0, 4'b0000, 32'h0000_0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 8'h20, 1'b0, 2'd2, 32'd2, 32'd3, 64'h0000_2222_0000_1111);

    for (int i = 0; i < 12; i++) begin
      reset     = vecs[i].rst;
      tb_valid  = vecs[i].valid;
      tb_addr   = vecs[i].addr;
      tb_mready = vecs[i].mrdy;
      tb_mdata  = vecs[i].mdata;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i),  64'(tb_ready),  64'(vecs[i].e_ready));
      chk($sformatf("vec%0d_mvalid", i), 64'(tb_mvalid), 64'(vecs[i].e_mvalid));
      chk($sformatf("vec%0d_maddr", i),  64'(tb_maddr),  64'(vecs[i].e_maddr));
      chk($sformatf("vec%0d_busy", i),   64'(tb_busy),   64'(vecs[i].e_busy));
      chk($sformatf("vec%0d_owner", i),  64'(tb_owner),  64'(vecs[i].e_owner));
      chk($sformatf("vec%0d_gc", i),     64'(tb_gc),     64'(vecs[i].e_gc));
      chk($sformatf("vec%0d_cf", i),     64'(tb_cf),     64'(vecs[i].e_cf));
      chk($sformatf("vec%0d_data", i),   tb_data,        vecs[i].e_data);
    end

    // Fairness: all four continuously valid, zero-wait memory.
    do_reset();
    tb_addr   = 32'h4433_2211;
    tb_valid  = 4'b1111;
    tb_mready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tb_mdata = 16'hA000 + 16'(k);
      wait_accept(k % 4, 1'b0);
      wait_response(k % 4, 16'hA000 + 16'(k));
    end
    chk("fair_gc", 64'(tb_gc), 64'd8);

    // Memory stall: five low mem ready samples while in READ.
    do_reset();
    tb_addr   = 32'h0000_0055;
    tb_valid  = 4'b0001;
    tb_mready = 1'b0;
    wait_accept(0, 1'b1);
    for (int s = 1; s <= 5; s++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_mvalid", s), 64'(tb_mvalid), 64'd1);
      chk($sformatf("stall%0d_maddr", s),  64'(tb_maddr),  64'h55);
      chk($sformatf("stall%0d_ready", s),  64'(tb_ready),  64'h0);
      chk($sformatf("stall%0d_busy", s),   64'(tb_busy),   64'd1);
    end
    tb_mready = 1'b1;
    tb_mdata  = 16'hCAFE;
    wait_response(0, 16'hCAFE);

    // Reset in READ, then pointer-from-zero and wrap checks.
    do_reset();
    tb_addr   = 32'h4030_2010;
    tb_mready = 1'b1;
    tb_mdata  = 16'h5A5A;
    tb_valid  = 4'b0100;
    wait_accept(2, 1'b1);
    wait_response(2, 16'h5A5A);
    tb_mready = 1'b0;
    tb_valid  = 4'b0010;
    wait_accept(1, 1'b1);
    reset     = 1'b1;
    tb_mready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mvalid", 64'(tb_mvalid), 64'd0);
    chk("rst_ready",  64'(tb_ready),  64'h0);
    chk("rst_busy",   64'(tb_busy),   64'd0);
    chk("rst_gc",     64'(tb_gc),     64'd0);
    chk("rst_cf",     64'(tb_cf),     64'd0);
    chk("rst_owner",  64'(tb_owner),  64'd0);
    chk("rst_data",   tb_data,        64'h0);
    @(negedge clk);
    chk("rst_no_resp", 64'(tb_ready), 64'h0);
    tb_mdata = 16'h0101;
    tb_valid = 4'b1010;
    wait_accept(1, 1'b1);
    wait_response(1, 16'h0101);
    tb_mdata = 16'h0303;
    wait_accept(3, 1'b1);
    wait_response(3, 16'h0303);
    tb_mdata = 16'h0A0A;
    tb_valid = 4'b1001;
    wait_accept(0, 1'b1);
    wait_response(0, 16'h0A0A);
    tb_mdata = 16'h0B0B;
    wait_accept(3, 1'b1);
    wait_response(3, 16'h0B0B);
    chk("wrap_gc", 64'(tb_gc), 64'd4);

    // Randomized traffic against the timeline model.
    reset     = 1'b1;
    tb_valid  = 4'b0000;
    tb_mready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_act = 1'b0; m_acc = -1; m_rsp = -1; m_own = 0; m_ptr = 0;
    m_gc = 32'd0; m_cf = 32'd0; m_addr = 8'h00;
    pend = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      m_data[i] = 16'h0000;
      raddr[i]  = 8'h00;
    end
    for (int c = 0; c < 2000; c++) begin
      check_model(c);
      if (m_act && c == m_acc) pend[m_own] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i]  = 1'b1;
          raddr[i] = 8'($urandom);
        end
      end
      tb_valid  = pend;
      tb_addr   = {raddr[3], raddr[2], raddr[1], raddr[0]};
      tb_mready = ($urandom_range(2) == 0);
      tb_mdata  = 16'($urandom);
      if (!m_busy(c)) begin
        g = 4'b0000;
        if (pend != 4'b0000) begin
          w      = rr_first(pend, m_ptr);
          g[w]   = 1'b1;
          m_act  = 1'b1;
          m_own  = w;
          m_acc  = c + 1;
          m_rsp  = -1;
          m_addr = raddr[w];
          m_gc   = m_gc + 32'd1;
        end
        if ((pend & ~g) != 4'b0000) m_cf = m_cf + 32'd1;
      end else begin
        if (pend != 4'b0000) m_cf = m_cf + 32'd1;
        if (m_read(c) && tb_mready) begin
          m_rsp         = c + 1;
          m_data[m_own] = tb_mdata;
          m_ptr         = (m_own + 1) % 4;
        end
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
